// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - block store / chunked transfer memory controller (optional mc_err via MC_ERR_EN)
module mem_controller #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CHUNK  = 4
) (
    input  logic                      mc_clk,
    input  logic                      mc_reset,
    input  logic [2:0]                mc_data_contition,
    input  logic [5:0]                mc_data_length,
    input  logic [DATA_W-1:0]         mc_data_in,
    input  logic                      mc_data_in_valid,
    output logic                      mc_data_in_ready,
    output logic                      mc_done,
    output logic                      mc_data_done,
    output logic [DATA_W*CHUNK-1:0]   mc_reg_data,
    output logic [2:0]                mc_reg_count
`ifdef MC_ERR_EN
    ,
    output logic                      mc_err
`endif
);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_XFER  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b100;

    typedef enum logic [1:0] {
        M_IDLE,
        M_STORE,
        M_XFER,
        M_HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic [5:0]                len_q, len_d;
    logic [5:0]                wr_ptr_q, wr_ptr_d;
    logic [5:0]                rd_ptr_q, rd_ptr_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [DATA_W*CHUNK-1:0]   xbuf_q, xbuf_d;
    logic [DATA_W*CHUNK-1:0]   reg_data_q, reg_data_d;
    logic [2:0]                reg_count_q, reg_count_d;
    logic                      done_q, done_d;
    logic                      data_done_q, data_done_d;
    logic                      ready_q, ready_d;

    // Memory array is deliberately never reset
    logic [DATA_W-1:0]         mem [DEPTH];
    logic                      mem_wr_en;

    // Words still owed to the core, and the size of the next chunk
    logic [5:0]                remain;
    logic [5:0]                n_words;
    logic [5:0]                rd_addr;
    logic [5:0]                rd_end;

    assign remain  = len_q - rd_ptr_q;
    assign n_words = (remain > 6'(CHUNK)) ? 6'(CHUNK) : remain;
    assign rd_addr = rd_ptr_q + cnt_q;
    assign rd_end  = rd_ptr_q + n_words;

    // Next-state and next-output computation for the whole controller
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        xbuf_d      = xbuf_q;
        reg_data_d  = reg_data_q;
        reg_count_d = reg_count_q;
        done_d      = 1'b0;
        data_done_d = data_done_q;
        mem_wr_en   = 1'b0;

        case (state_q)
            M_IDLE: begin
                case (mc_data_contition)
                    OP_STORE: begin
                        len_d       = mc_data_length;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        data_done_d = 1'b0;
                        state_d     = M_STORE;
                    end
                    OP_XFER: begin
                        cnt_d   = '0;
                        xbuf_d  = '0;
                        state_d = M_XFER;
                    end
                    OP_NONE: begin
                        rd_ptr_d    = '0;
                        data_done_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            M_STORE: begin
                if (mc_data_contition != OP_STORE) begin
                    state_d = M_IDLE;
                end else if (wr_ptr_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = M_HOLD;
                end else if (mc_data_in_valid && ready_q) begin
                    mem_wr_en = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 6'd1;
                end
            end
            M_XFER: begin
                if (mc_data_contition != OP_XFER) begin
                    state_d = M_IDLE;
                end else if (cnt_q == n_words) begin
                    // Last read has landed in the staging buffer; publish it
                    done_d      = 1'b1;
                    reg_data_d  = xbuf_q;
                    reg_count_d = n_words[2:0];
                    rd_ptr_d    = rd_end;
                    if (rd_end == len_q) begin
                        data_done_d = 1'b1;
                    end
                    state_d = M_HOLD;
                end else begin
                    xbuf_d[cnt_q*DATA_W +: DATA_W] = mem[rd_addr];
                    cnt_d = cnt_q + 6'd1;
                end
            end
            M_HOLD: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase

        ready_d = (state_d == M_STORE) && (wr_ptr_d < len_d);
    end

    // Controller state and registered outputs
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state_q     <= M_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            xbuf_q      <= '0;
            reg_data_q  <= '0;
            reg_count_q <= '0;
            done_q      <= 1'b0;
            data_done_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            xbuf_q      <= xbuf_d;
            reg_data_q  <= reg_data_d;
            reg_count_q <= reg_count_d;
            done_q      <= done_d;
            data_done_q <= data_done_d;
            ready_q     <= ready_d;
        end
    end

    // Store path write port
    always_ff @(posedge mc_clk) begin
        if (mem_wr_en) begin
            mem[wr_ptr_q] <= mc_data_in;
        end
    end

    assign mc_data_in_ready = ready_q;
    assign mc_done          = done_q;
    assign mc_data_done     = data_done_q;
    assign mc_reg_data      = reg_data_q;
    assign mc_reg_count     = reg_count_q;

`ifdef MC_ERR_EN
    logic err_q, err_d;
    logic abort;

    assign abort = ((state_q == M_STORE) && (mc_data_contition != OP_STORE)) ||
                   ((state_q == M_XFER)  && (mc_data_contition != OP_XFER));

    // Sticky error: aborted operation or data offered while not ready
    always_comb begin
        err_d = err_q | abort |
                (mc_data_in_valid && !ready_q && (state_q != M_IDLE));
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mc_err = err_q;
`endif

endmodule
